// File: rtl/hovalaag_stream_core.sv
// Hovalaag CPU core with valid/ready input channels and a FIFO per output channel.
// The core holds the presented instruction (stalls) instead of dropping or inventing data.

module hovalaag_out_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              ready_i,
    output logic              full_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d, rd_nx;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic              pop;

    // The head entry lives in its own register so out*_data comes straight from a flop.
    always_comb begin
        pop    = ready_i && (cnt_q != '0);
        rd_nx  = rd_q + PW'(1);
        wr_d   = push_i ? wr_q + PW'(1) : wr_q;
        rd_d   = pop ? rd_nx : rd_q;
        cnt_d  = cnt_q + CW'(push_i) - CW'(pop);
        head_d = head_q;
        if (pop) begin
            if (cnt_q > CW'(1)) begin
                head_d = mem_q[rd_nx];
            end else if (push_i) begin
                head_d = wdata_i;
            end
        end else if ((cnt_q == '0) && push_i) begin
            head_d = wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            head_q <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            head_q <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_q] <= wdata_i;
        end
    end

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign valid_o = (cnt_q != '0);
    assign data_o  = head_q;
endmodule

module hovalaag_stream_core #(
    parameter int OUT_DEPTH = 4,
    parameter bit IN_STALL  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    output logic [7:0]  pc,
    input  logic [11:0] in1_data,
    input  logic [11:0] in2_data,
    input  logic        in1_valid,
    input  logic        in2_valid,
    output logic        in1_ready,
    output logic        in2_ready,
    output logic [11:0] out1_data,
    output logic [11:0] out2_data,
    output logic        out1_valid,
    output logic        out2_valid,
    input  logic        out1_ready,
    input  logic        out2_ready,
    output logic        stall,
    output logic [11:0] a_dbg,
    output logic [11:0] b_dbg,
    output logic [11:0] c_dbg,
    output logic [11:0] d_dbg
);
    logic [11:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d, w_q, w_d;
    logic        f_q, f_d;
    logic [7:0]  pc_q, pc_d, pc_inc, l;
    logic signed [12:0] a13, b13, c13;
    logic [12:0] res;
    logic [11:0] m, k, sel_data;
    logic        nf, ch2, rd_in, sel_valid, full_sel, hold, exec;
    logic        full1, full2, push1, push2;

    function automatic logic [12:0] alu(input logic [3:0] op, input logic signed [12:0] a,
                                        input logic signed [12:0] b, input logic signed [12:0] c,
                                        input logic f);
        logic signed [12:0] fx;
        fx = $signed({12'd0, f});
        case (op)
            4'd0:    alu = a;
            4'd1:    alu = b;
            4'd2:    alu = c;
            4'd3:    alu = a + b;
            4'd4:    alu = a - b;
            4'd5:    alu = b - a;
            4'd6:    alu = a + b + fx;
            4'd7:    alu = a - b - fx;
            4'd8:    alu = a & b;
            4'd9:    alu = a | b;
            4'd10:   alu = a ^ b;
            4'd11:   alu = ~a;
            4'd12:   alu = a + 13'sd1;
            4'd13:   alu = a - 13'sd1;
            4'd14:   alu = a <<< 1;
            default: alu = -a;
        endcase
    endfunction

    always_comb begin
        a13       = $signed({a_q[11], a_q});
        b13       = $signed({b_q[11], b_q});
        c13       = $signed({c_q[11], c_q});
        res       = alu(instr[31:28], a13, b13, c13, f_q);
        m         = res[11:0];
        nf        = res[12];
        k         = instr[12] ? instr[11:0] : {{6{instr[11]}}, instr[11:6]};
        l         = instr[12] ? instr[7:0] : {2'b00, instr[5:0]};
        ch2       = instr[13];
        rd_in     = (instr[27:26] == 2'b11);
        sel_valid = ch2 ? in2_valid : in1_valid;
        sel_data  = ch2 ? in2_data : in1_data;
        full_sel  = ch2 ? full2 : full1;
        // A full FIFO holds the core even while it is being popped: no pass-through.
        hold      = (rd_in && IN_STALL && !sel_valid) || (instr[14] && full_sel);
        exec      = !rst && !hold;

        case (instr[27:26])
            2'b01:   a_d = m;
            2'b10:   a_d = d_q;
            2'b11:   a_d = sel_data;
            default: a_d = a_q;
        endcase
        case (instr[25:24])
            2'b01:   b_d = m;
            2'b10:   b_d = a_q;
            2'b11:   b_d = k;
            default: b_d = b_q;
        endcase
        case (instr[23:22])
            2'b01:   c_d = m;
            2'b10,
            2'b11:   c_d = c_q - 12'd1;
            default: c_d = c_q;
        endcase
        d_d = instr[21] ? a_q : d_q;
        case (instr[20:19])
            2'b01:   w_d = m;
            2'b10:   w_d = a_q;
            2'b11:   w_d = k;
            default: w_d = w_q;
        endcase
        case (instr[18:17])
            2'b01:   f_d = (res == 13'd0);
            2'b10:   f_d = nf;
            2'b11:   f_d = !nf && (m != 12'd0);
            default: f_d = f_q;
        endcase

        pc_inc = pc_q + 8'd1;
        case (instr[16:15])
            2'b01:   pc_d = l;
            2'b10:   pc_d = f_q ? l : pc_inc;
            2'b11:   pc_d = f_q ? pc_inc : l;
            default: pc_d = pc_inc;
        endcase
        // DECNZ branches unless this pass takes C from 1 to 0.
        if ((instr[23:22] == 2'b11) && (c_q != 12'd1)) begin
            pc_d = l;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q  <= '0;
            b_q  <= '0;
            c_q  <= '0;
            d_q  <= '0;
            w_q  <= '0;
            f_q  <= 1'b0;
            pc_q <= '0;
        end else if (!hold) begin
            a_q  <= a_d;
            b_q  <= b_d;
            c_q  <= c_d;
            d_q  <= d_d;
            w_q  <= w_d;
            f_q  <= f_d;
            pc_q <= pc_d;
        end
    end

    assign push1     = exec && instr[14] && !ch2;
    assign push2     = exec && instr[14] && ch2;
    assign in1_ready = exec && rd_in && !ch2;
    assign in2_ready = exec && rd_in && ch2;
    assign stall     = !rst && hold;

    hovalaag_out_fifo #(.DEPTH(OUT_DEPTH), .DATA_W(12)) u_fifo1 (
        .clk(clk), .rst(rst), .push_i(push1), .wdata_i(w_q), .ready_i(out1_ready),
        .full_o(full1), .valid_o(out1_valid), .data_o(out1_data)
    );

    hovalaag_out_fifo #(.DEPTH(OUT_DEPTH), .DATA_W(12)) u_fifo2 (
        .clk(clk), .rst(rst), .push_i(push2), .wdata_i(w_q), .ready_i(out2_ready),
        .full_o(full2), .valid_o(out2_valid), .data_o(out2_data)
    );

    assign pc    = pc_q;
    assign a_dbg = a_q;
    assign b_dbg = b_q;
    assign c_dbg = c_q;
    assign d_dbg = d_q;
endmodule

// File: tb/tb_hovalaag_stream_core.sv
// Scoreboard bench for hovalaag_stream_core: instruction-level reference model,
// directed scenarios followed by randomized programs and handshakes.

module tb_hovalaag_stream_core;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] rom [256];
    logic [31:0] instr;
    logic [7:0]  pc;
    logic [11:0] in1_data, in2_data, out1_data, out2_data;
    logic        in1_valid, in2_valid, in1_ready, in2_ready;
    logic        out1_valid, out2_valid, out1_ready, out2_ready, stall;
    logic [11:0] a_dbg, b_dbg, c_dbg, d_dbg;

    // second core in legacy (no input stall) mode
    logic [31:0] instr_ls;
    logic [7:0]  pc_ls;
    logic [11:0] in2_data_ls, out1_data_ls, out2_data_ls, a_ls, b_ls, c_ls, d_ls;
    logic        in1_ready_ls, in2_ready_ls, out1_valid_ls, out2_valid_ls, stall_ls;

    assign instr = rom[pc];

    hovalaag_stream_core #(.OUT_DEPTH(DEPTH), .IN_STALL(1'b1)) dut (
        .clk(clk), .rst(rst), .instr(instr), .pc(pc),
        .in1_data(in1_data), .in2_data(in2_data), .in1_valid(in1_valid), .in2_valid(in2_valid),
        .in1_ready(in1_ready), .in2_ready(in2_ready),
        .out1_data(out1_data), .out2_data(out2_data), .out1_valid(out1_valid), .out2_valid(out2_valid),
        .out1_ready(out1_ready), .out2_ready(out2_ready), .stall(stall),
        .a_dbg(a_dbg), .b_dbg(b_dbg), .c_dbg(c_dbg), .d_dbg(d_dbg)
    );

    hovalaag_stream_core #(.OUT_DEPTH(DEPTH), .IN_STALL(1'b0)) dut_ls (
        .clk(clk), .rst(rst), .instr(instr_ls), .pc(pc_ls),
        .in1_data(12'd0), .in2_data(in2_data_ls), .in1_valid(1'b0), .in2_valid(1'b0),
        .in1_ready(in1_ready_ls), .in2_ready(in2_ready_ls),
        .out1_data(out1_data_ls), .out2_data(out2_data_ls), .out1_valid(out1_valid_ls),
        .out2_valid(out2_valid_ls), .out1_ready(1'b1), .out2_ready(1'b1), .stall(stall_ls),
        .a_dbg(a_ls), .b_dbg(b_ls), .c_dbg(c_ls), .d_dbg(d_ls)
    );

    int n_vec = 0;
    int n_bad = 0;
    int m_a, m_b, m_c, m_d, m_w, m_f, m_pc, m_cnt1, m_cnt2;
    bit m_valid = 1'b0;
    bit m_after_rst = 1'b0;
    int sb1[$];
    int sb2[$];
    int pops1 = 0;
    int pops2 = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int alu, input int aop, input int bop, input int cop,
                                       input int d, input int wop, input int fop, input int pcop,
                                       input int outen, input int ch, input int lng, input int imm);
        logic [31:0] v;
        v = '0;
        v[31:28] = 4'(alu);
        v[27:26] = 2'(aop);
        v[25:24] = 2'(bop);
        v[23:22] = 2'(cop);
        v[21]    = 1'(d);
        v[20:19] = 2'(wop);
        v[18:17] = 2'(fop);
        v[16:15] = 2'(pcop);
        v[14]    = 1'(outen);
        v[13]    = 1'(ch);
        v[12]    = 1'(lng);
        v[11:0]  = 12'(imm);
        return v;
    endfunction

    function automatic int sx12(input int v);
        return ((v & 'h800) != 0) ? v - 4096 : v;
    endfunction

    // 13-bit result {newF, M} from sign-extended integer operands
    function automatic int m_alu(input int op, input int a, input int b, input int c, input int f);
        int r;
        case (op)
            0:  r = a;
            1:  r = b;
            2:  r = c;
            3:  r = a + b;
            4:  r = a - b;
            5:  r = b - a;
            6:  r = a + b + f;
            7:  r = a - b - f;
            8:  r = a & b;
            9:  r = a | b;
            10: r = a ^ b;
            11: r = ~a;
            12: r = a + 1;
            13: r = a - 1;
            14: r = a * 2;
            default: r = -a;
        endcase
        return r & 'h1FFF;
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 32'd0;
    endtask

    task automatic model_cycle();
        logic [31:0] ins;
        int op, aop, bop, cop, dd, wop, fop, pcop, outen, ch, lng;
        int k, l, sv, sd, full, hold, r, m, nf, npc;
        if (!m_valid) begin
            if (rst) begin
                m_valid = 1'b1;
                m_a = 0; m_b = 0; m_c = 0; m_d = 0; m_w = 0; m_f = 0; m_pc = 0;
                m_cnt1 = 0; m_cnt2 = 0;
                m_after_rst = 1'b1;
            end
            return;
        end
        ins   = rom[m_pc];
        op    = int'(ins[31:28]);
        aop   = int'(ins[27:26]);
        bop   = int'(ins[25:24]);
        cop   = int'(ins[23:22]);
        dd    = int'(ins[21]);
        wop   = int'(ins[20:19]);
        fop   = int'(ins[18:17]);
        pcop  = int'(ins[16:15]);
        outen = int'(ins[14]);
        ch    = int'(ins[13]);
        lng   = int'(ins[12]);
        k     = lng ? int'(ins[11:0]) : (ins[11] ? int'(ins[11:6]) + 'hFC0 : int'(ins[11:6]));
        l     = lng ? int'(ins[7:0]) : int'(ins[5:0]);
        sv    = ch ? int'(in2_valid) : int'(in1_valid);
        sd    = ch ? int'(in2_data) : int'(in1_data);
        full  = (ch ? m_cnt2 : m_cnt1) == DEPTH;
        hold  = ((aop == 3) && !sv) || (outen && full);

        if (m_after_rst) begin
            chk("reset_out1_data", int'(out1_data), 0);
            chk("reset_out2_data", int'(out2_data), 0);
        end
        chk("pc", int'(pc), m_pc);
        chk("a_dbg", int'(a_dbg), m_a);
        chk("b_dbg", int'(b_dbg), m_b);
        chk("c_dbg", int'(c_dbg), m_c);
        chk("d_dbg", int'(d_dbg), m_d);
        chk("out1_valid", int'(out1_valid), int'(m_cnt1 > 0));
        chk("out2_valid", int'(out2_valid), int'(m_cnt2 > 0));
        chk("stall", int'(stall), int'(!rst && hold));
        chk("in1_ready", int'(in1_ready), int'(!rst && !hold && aop == 3 && ch == 0));
        chk("in2_ready", int'(in2_ready), int'(!rst && !hold && aop == 3 && ch == 1));

        if (rst) begin
            m_a = 0; m_b = 0; m_c = 0; m_d = 0; m_w = 0; m_f = 0; m_pc = 0;
            m_cnt1 = 0; m_cnt2 = 0;
            sb1.delete();
            sb2.delete();
            m_after_rst = 1'b1;
            return;
        end
        m_after_rst = 1'b0;
        if (out1_ready && m_cnt1 > 0) m_cnt1--;
        if (out2_ready && m_cnt2 > 0) m_cnt2--;
        if (hold) return;

        r  = m_alu(op, sx12(m_a), sx12(m_b), sx12(m_c), m_f);
        m  = r & 'hFFF;
        nf = (r >> 12) & 1;
        case (pcop)
            0: npc = m_pc + 1;
            1: npc = l;
            2: npc = m_f ? l : m_pc + 1;
            default: npc = m_f ? m_pc + 1 : l;
        endcase
        if (cop == 3 && m_c != 1) npc = l;
        if (outen) begin
            if (ch == 0) begin sb1.push_back(m_w); m_cnt1++; end
            else begin sb2.push_back(m_w); m_cnt2++; end
        end
        begin
            int na, nb, nc, nd, nw, nfl;
            na  = (aop == 1) ? m : (aop == 2) ? m_d : (aop == 3) ? sd : m_a;
            nb  = (bop == 1) ? m : (bop == 2) ? m_a : (bop == 3) ? k : m_b;
            nc  = (cop == 1) ? m : (cop >= 2) ? ((m_c - 1) & 'hFFF) : m_c;
            nd  = dd ? m_a : m_d;
            nw  = (wop == 1) ? m : (wop == 2) ? m_a : (wop == 3) ? k : m_w;
            nfl = (fop == 1) ? int'(r == 0) : (fop == 2) ? nf : (fop == 3) ? int'(!nf && m != 0) : m_f;
            m_a = na; m_b = nb; m_c = nc; m_d = nd; m_w = nw; m_f = nfl;
            m_pc = npc & 'hFF;
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // output monitor: every DUT pop is checked against the scoreboard
    always @(negedge clk) begin
        if (out1_valid === 1'b1 && out1_ready === 1'b1) begin
            if (sb1.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL out1_pop: got unexpected 0x%0h, want no entry", out1_data);
            end else begin
                chk("out1_data", int'(out1_data), sb1.pop_front());
                pops1++;
            end
        end
        if (out2_valid === 1'b1 && out2_ready === 1'b1) begin
            if (sb2.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL out2_pop: got unexpected 0x%0h, want no entry", out2_data);
            end else begin
                chk("out2_data", int'(out2_data), sb2.pop_front());
                pops2++;
            end
        end
    end

    initial begin
        rst = 1'b1;
        in1_valid = 1'b0; in2_valid = 1'b0; in1_data = '0; in2_data = '0;
        out1_ready = 1'b0; out2_ready = 1'b0;
        instr_ls = mk(0, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        in2_data_ls = 12'h7FF;
        clear_rom();
        @(posedge clk); #1;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("reset_pc", int'(pc), 0);
        chk("reset_out1_valid", int'(out1_valid), 0);

        // legacy mode: reads in2_data without waiting for valid
        chk("ls_stall", int'(stall_ls), 0);
        chk("ls_in2_ready", int'(in2_ready_ls), 1);
        step();
        chk("ls_a", int'(a_ls), 'h7FF);

        // stalled input read
        clear_rom();
        rom[0] = mk(0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        repeat (3) begin
            #1;
            chk("t1_stall", int'(stall), 1);
            chk("t1_pc_held", int'(pc), 0);
            step();
        end
        in1_valid = 1'b1; in1_data = 12'h123;
        #1;
        chk("t1_in1_ready", int'(in1_ready), 1);
        step();
        in1_valid = 1'b0;
        #1;
        chk("t1_a", int'(a_dbg), 'h123);
        chk("t1_pc", int'(pc), 1);
        chk("t1_ready_drop", int'(in1_ready), 0);

        // output back-pressure on channel 2
        clear_rom();
        rom[0] = mk(0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 1, 'h055);
        for (int i = 1; i <= 6; i++) rom[i] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        do_reset();
        pops2 = 0;
        repeat (5) step();
        #1;
        chk("t2_stall", int'(stall), 1);
        chk("t2_pc", int'(pc), 5);
        step();
        step();
        chk("t2_pc_frozen", int'(pc), 5);
        out2_ready = 1'b1;
        #1;
        chk("t2_full_pop_still_stalls", int'(stall), 1);
        step();
        chk("t2_stall_clear", int'(stall), 0);
        repeat (12) step();
        out2_ready = 1'b0;
        #1;
        chk("t2_drained", pops2, 6);
        chk("t2_empty", int'(out2_valid), 0);

        // DECNZ loop
        clear_rom();
        rom[0]    = mk(0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 1, 3);
        rom[1]    = mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        rom[2]    = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 'h10);
        rom[8'h10] = mk(0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1, 'h10);
        rom[8'h11] = mk(0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1, 'h20);
        do_reset();
        repeat (4) step();
        chk("t3_c_first", int'(c_dbg), 2);
        chk("t3_pc_first", int'(pc), 'h10);
        repeat (2) step();
        chk("t3_c_end", int'(c_dbg), 0);
        chk("t3_fallthrough", int'(pc), 'h11);
        step();
        chk("t3_c_wrap", int'(c_dbg), 'hFFF);
        chk("t3_wrap_branch", int'(pc), 'h20);

        // IN and OUT on the same channel
        clear_rom();
        for (int i = 0; i <= 4; i++) rom[i] = mk(0, (i == 0 || i == 4) ? 3 : 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        do_reset();
        in1_valid = 1'b1; in1_data = 12'h2A5;
        #1;
        chk("t5_both_ready", int'(in1_ready), 1);
        step();
        chk("t5_one_cycle_pc", int'(pc), 1);
        chk("t5_a", int'(a_dbg), 'h2A5);
        repeat (3) step();
        #1;
        chk("t5_full_stall", int'(stall), 1);
        chk("t5_full_no_ready", int'(in1_ready), 0);
        out1_ready = 1'b1; in1_data = 12'h19C;
        step();
        out1_ready = 1'b0;
        #1;
        chk("t5_resume_ready", int'(in1_ready), 1);
        step();
        in1_valid = 1'b0;
        chk("t5_a2", int'(a_dbg), 'h19C);
        chk("t5_pc2", int'(pc), 5);
        out1_ready = 1'b1;
        repeat (6) step();
        out1_ready = 1'b0;

        // reset mid-stream
        clear_rom();
        rom[0] = mk(0, 0, 0, 0, 0, 3, 0, 1, 0, 0, 1, 'h43F);
        for (int i = 'h3F; i <= 'h41; i++) rom[i] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        do_reset();
        repeat (4) step();
        chk("t6_pc", int'(pc), 'h42);
        chk("t6_pending", int'(out1_valid), 1);
        clear_rom();
        do_reset();
        chk("t6_pc_reset", int'(pc), 0);
        chk("t6_valid_reset", int'(out1_valid), 0);
        out1_ready = 1'b1;
        repeat (5) step();
        out1_ready = 1'b0;
        chk("t6_no_emit", int'(out1_valid), 0);

        // randomized programs and handshakes
        for (int i = 0; i < 256; i++) rom[i] = $urandom;
        for (int n = 0; n < 2400; n++) begin
            int rp;
            rp = (n < 1200) ? 3 : 1;
            rst = ($urandom_range(0, 150) == 0);
            in1_valid = 1'($urandom_range(0, 1));
            in2_valid = 1'($urandom_range(0, 1));
            in1_data = 12'($urandom);
            in2_data = 12'($urandom);
            out1_ready = !rst && ($urandom_range(0, 3) < rp);
            out2_ready = !rst && ($urandom_range(0, 3) < rp);
            step();
        end
        rst = 1'b0;
        out1_ready = 1'b0;
        out2_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/hovalaag_stream_core.md
# hovalaag_stream_core

Stream-handshaked successor to the Hovalaag CPU core. It keeps the same 32-bit instruction format and datapath: A/B/C/D/W/F registers, 8-bit PC and the shared HovalaagALU function. Inputs gain valid/ready back-pressure, and each output channel gets a parametrised FIFO with valid/ready, so the core stalls instead of dropping or inventing data. It sits between the instruction ROM and the IN/OUT stream adapters in the top-level test harness.

## Interface
- OUT_DEPTH, 4, entries per output FIFO; power of 2, 2..16.
- IN_STALL, 1, 1 = stall when the selected input is not valid; 0 = never stall on input (legacy mode, reads in*_data as presented).
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- instr  in  32  instruction at address pc, combinational fetch, no pipelining.
- pc  out  8  current program counter.
- in1_data, in2_data  in  12  input channel data.
- in1_valid, in2_valid  in  1  input data present.
- in1_ready, in2_ready  out  1  combinational; high in the cycle the core consumes that channel.
- out1_data, out2_data  out  12  FIFO head data, registered.
- out1_valid, out2_valid  out  1  FIFO non-empty.
- out1_ready, out2_ready  in  1  consumer pop.
- stall  out  1  combinational; high when the presented instruction is held.
- a_dbg, b_dbg, c_dbg, d_dbg  out  12  register taps.

## Operation
- Instruction fields:
  - [31:28] ALU op; [27:26] A op (hold/M/D/IN); [25:24] B op (hold/M/A/K).
  - [23:22] C op (hold/M/DEC/DECNZ); [21] D<=A; [20:19] W op (hold/M/A/K).
  - [18:17] F op (hold / Z of {newF,M} / newF / !newF && M!=0); [16:15] PC op (+1 / L / F?L:+1 / F?+1:L).
  - [14] OUT enable; [13] channel select (0 = ch1, 1 = ch2, for both IN and OUT).
  - [12] long-immediate; K = [12] ? [11:0] : sext([11:6]); L = [12] ? [7:0] : zext([5:0]).
- ALU operands: A, B, C sign-extended to 13 bits, plus F. Result is {newF, M}.
- DECNZ (C op 11): C <= C-1; if C != 1 before the decrement, PC <= L and the PC op is overridden.
- DEC (C op 10) decrements with no branch. C wraps 0 -> 0xFFF.
- Execute condition, evaluated per cycle:
  - need_in = (A op == 11) && IN_STALL && !selected in*_valid.
  - need_out = bit14 && selected FIFO full.
  - stall = need_in || need_out.
- Stalled cycle: no architectural register, PC or FIFO push changes; in*_ready = 0. Consumer pops continue.
- Executed cycle:
  - All register updates occur in parallel from pre-edge values.
  - in*_ready = 1 on the selected channel only if A op == 11.
  - If bit14 is set, pre-edge W is pushed to the selected FIFO.
- FIFO rules:
  - A push into a full FIFO never occurs, because the core stalls instead.
  - A full FIFO stalls even if it is being popped in the same cycle (no pass-through).
  - Simultaneous push and pop on a non-empty FIFO leaves the count unchanged.
- Reset (rst high at an edge):
  - A, B, C, D, W, F, PC are cleared to 0.
  - Both FIFOs are emptied; contents are discarded mid-stream.
  - in*_ready = 0 and stall = 0 while rst is high.

## Timing
- One instruction per cycle when not stalled; pc updates at the executing edge.
- Input: data is sampled on the edge where in*_valid && in*_ready. in*_ready depends only on instr, in*_valid and FIFO state, never on out*_ready.
- Output latency: push at edge N; out*_valid = 1 and out*_data = W after edge N, if the FIFO was empty.
- Pop: occurs at the edge with out*_valid && out*_ready. The next entry, or valid = 0, appears after that edge.
- Reset values after a reset edge: pc = 0, out*_valid = 0, out*_data = 0, debug taps = 0.
- FIFO pointers wrap modulo OUT_DEPTH. Full = count == OUT_DEPTH; empty = count == 0.

## Test plan
- Stalled input read: A<=IN1 with in1_valid = 0 for 3 cycles, then in1_data = 0x123 valid. Required: pc is held 3 cycles with stall = 1, then a_dbg = 0x123, pc + 1, and one in1_ready pulse.
- Output back-pressure (OUT_DEPTH = 4, out2_ready = 0): W <= K = 0x055, then 6 instructions outputting to ch2. Required: 4 pushes, then stall asserts with pc frozen. Raising out2_ready drains 4 x 0x055, and the stall clears one cycle after the first pop.
- DECNZ loop: C = 3, DECNZ to L = 0x10. Required: branches twice, falls through on the third pass with C = 0; a C = 0 start wraps to 0xFFF and branches.
- IN_STALL = 0: A<=IN2 with in2_valid = 0 and in2_data = 0x7FF. Required: no stall, A = 0x7FF, in2_ready = 1.
- Simultaneous IN and OUT on the same channel, with both available: executes in 1 cycle. With in1 valid but FIFO1 full: stalls and in1_ready = 0.
- Reset mid-stream with 3 FIFO entries and pc = 0x42. Required: out*_valid = 0 and pc = 0 after the edge; no data emitted after reset.
